// File: rtl/alu_pkg.sv
// Shared ALU op encoding, FSM state encoding and helpers for the decode and execute stages.
package alu_pkg;

   localparam int unsigned DEF_XLEN    = 32;
   localparam int unsigned DEF_SHAMT_W = 5;
   localparam int unsigned OP_W        = 4;

   localparam logic [OP_W-1:0] ALU_ADD  = 4'b0000;
   localparam logic [OP_W-1:0] ALU_SLL  = 4'b0001;
   localparam logic [OP_W-1:0] ALU_SLT  = 4'b0010;
   localparam logic [OP_W-1:0] ALU_SLTU = 4'b0011;
   localparam logic [OP_W-1:0] ALU_XOR  = 4'b0100;
   localparam logic [OP_W-1:0] ALU_SRL  = 4'b0101;
   localparam logic [OP_W-1:0] ALU_OR   = 4'b0110;
   localparam logic [OP_W-1:0] ALU_AND  = 4'b0111;
   localparam logic [OP_W-1:0] ALU_SUB  = 4'b1000;
   localparam logic [OP_W-1:0] ALU_SRA  = 4'b1101;

   localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
   localparam logic [1:0] ST_SHIFT_ENC = 2'd1;
   localparam logic [1:0] ST_DONE_ENC  = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE  = ST_IDLE_ENC,
      ST_SHIFT = ST_SHIFT_ENC,
      ST_DONE  = ST_DONE_ENC
   } alu_state_e;

   function automatic logic is_shift(input logic [OP_W-1:0] op);
      return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
   endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle ALU datapath with illegal-opcode detection.
module alu_comb_core
   import alu_pkg::*;
#(
   parameter int unsigned XLEN = DEF_XLEN
) (
   input  logic [OP_W-1:0] op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic [XLEN-1:0] res_c,
   output logic            illegal_c
);

   always_comb begin
      res_c     = '0;
      illegal_c = 1'b0;
      case (op)
         ALU_ADD:  res_c = a + b;
         ALU_SUB:  res_c = a - b;
         ALU_SLT:  res_c = XLEN'($signed(a) < $signed(b));
         ALU_SLTU: res_c = XLEN'(a < b);
         ALU_XOR:  res_c = a ^ b;
         ALU_OR:   res_c = a | b;
         ALU_AND:  res_c = a & b;
         // only reached for a zero shift amount; nonzero shifts iterate in the top
         ALU_SLL, ALU_SRL, ALU_SRA: res_c = a;
         default:  illegal_c = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_seq_exec.sv
// Multi-cycle ALU execute unit: single-cycle logic/arith, bit-serial shifts, valid/ready on both sides.
module alu_seq_exec
   import alu_pkg::*;
#(
   parameter int unsigned XLEN    = DEF_XLEN,
   parameter int unsigned SHAMT_W = DEF_SHAMT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OP_W-1:0]   alu_op,
   input  logic [XLEN-1:0]   op_a,
   input  logic [XLEN-1:0]   op_b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   result,
   output logic              zero,
   output logic              illegal
);

   alu_state_e           state_q, state_d;
   logic [XLEN-1:0]      acc_q, acc_d;
   logic [SHAMT_W-1:0]   cnt_q, cnt_d;
   logic [OP_W-1:0]      sop_q, sop_d;
   logic [XLEN-1:0]      result_q, result_d;
   logic                 zero_q, zero_d;
   logic                 illegal_q, illegal_d;
   logic                 out_valid_q;
   logic                 in_ready_q;

   logic [XLEN-1:0]      core_res_c;
   logic                 core_illegal_c;
   logic [XLEN-1:0]      acc_next_c;
   logic [SHAMT_W-1:0]   shamt_c;

   assign shamt_c = op_b[SHAMT_W-1:0];

   alu_comb_core #(
      .XLEN (XLEN)
   ) u_core (
      .op        (alu_op),
      .a         (op_a),
      .b         (op_b),
      .res_c     (core_res_c),
      .illegal_c (core_illegal_c)
   );

   // One-bit step of the shift accumulator for the latched shift kind
   always_comb begin
      acc_next_c = {acc_q[XLEN-2:0], 1'b0};
      if (sop_q == ALU_SRL) begin
         acc_next_c = {1'b0, acc_q[XLEN-1:1]};
      end else if (sop_q == ALU_SRA) begin
         acc_next_c = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
      end
   end

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      sop_d     = sop_q;
      result_d  = result_q;
      zero_d    = zero_q;
      illegal_d = illegal_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               if (is_shift(alu_op) && (shamt_c != '0)) begin
                  acc_d   = op_a;
                  cnt_d   = shamt_c;
                  sop_d   = alu_op;
                  state_d = ST_SHIFT;
               end else begin
                  result_d  = core_res_c;
                  zero_d    = (core_res_c == '0);
                  illegal_d = core_illegal_c;
                  state_d   = ST_DONE;
               end
            end
         end
         ST_SHIFT: begin
            acc_d = acc_next_c;
            cnt_d = cnt_q - SHAMT_W'(1);
            if (cnt_q == SHAMT_W'(1)) begin
               result_d  = acc_next_c;
               zero_d    = (acc_next_c == '0);
               illegal_d = 1'b0;
               state_d   = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // flush wins over accept and pop; the last presented result stays visible
      if (flush) begin
         state_d   = ST_IDLE;
         cnt_d     = '0;
         acc_d     = acc_q;
         sop_d     = sop_q;
         result_d  = result_q;
         zero_d    = zero_q;
         illegal_d = illegal_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         sop_q       <= ALU_SLL;
         result_q    <= '0;
         zero_q      <= 1'b0;
         illegal_q   <= 1'b0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         sop_q       <= sop_d;
         result_q    <= result_d;
         zero_q      <= zero_d;
         illegal_q   <= illegal_d;
         out_valid_q <= (state_d == ST_DONE);
         in_ready_q  <= (state_d == ST_IDLE);
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign zero      = zero_q;
   assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Directed bench for alu_seq_exec: vector table plus backpressure, flush and reset sequences.
module tb_alu_seq_exec;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  alu_op;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero;
   logic        illegal;

   int n_cmp = 0;
   int n_err = 0;

   alu_seq_exec dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_op    (alu_op),
      .op_a      (op_a),
      .op_b      (op_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .illegal   (illegal)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // edges = rising edges after the accept edge before out_valid is seen high
   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        z;
      logic        ill;
      int          edges;
   } vec_t;

   localparam int NV = 16;
   vec_t vecs [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_op(input vec_t v, input string tag);
      int n;
      chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
      alu_op   = v.op;
      op_a     = v.a;
      op_b     = v.b;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 40) begin
         step();
         n++;
      end
      chk({tag, " latency"}, 32'(n), 32'(v.edges));
      chk({tag, " result"}, result, v.res);
      chk({tag, " zero"}, 32'(zero), 32'(v.z));
      chk({tag, " illegal"}, 32'(illegal), 32'(v.ill));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk({tag, " pop"}, 32'(out_valid), 32'd0);
   endtask

   task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      alu_op   = op;
      op_a     = a;
      op_b     = b;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   initial begin
      logic seen;
      vec_t v;
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      alu_op = '0; op_a = '0; op_b = '0;

      vecs[0]  = '{4'h0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 0};
      vecs[1]  = '{4'h8, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, 0};
      vecs[2]  = '{4'hD, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0, 1'b0, 4};
      vecs[3]  = '{4'h5, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0, 1'b0, 4};
      vecs[4]  = '{4'h1, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0, 1'b0, 31};
      vecs[5]  = '{4'h2, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 0};
      vecs[6]  = '{4'h3, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 0};
      vecs[7]  = '{4'h1, 32'h1234_5678, 32'h0000_0020, 32'h1234_5678, 1'b0, 1'b0, 0};
      vecs[8]  = '{4'h4, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1'b0, 0};
      vecs[9]  = '{4'h6, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 1'b0, 1'b0, 0};
      vecs[10] = '{4'h7, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 0};
      vecs[11] = '{4'hF, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 0};
      vecs[12] = '{4'h9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1, 0};
      vecs[13] = '{4'hD, 32'h4000_0000, 32'h0000_0001, 32'h2000_0000, 1'b0, 1'b0, 1};
      vecs[14] = '{4'h5, 32'hFFFF_FFFF, 32'h0000_001F, 32'h0000_0001, 1'b0, 1'b0, 31};
      vecs[15] = '{4'h0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 0};

      repeat (2) step();
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset result", result, 32'd0);
      chk("reset zero", 32'(zero), 32'd0);
      chk("reset illegal", 32'(illegal), 32'd0);
      rst_n = 1'b1;
      step();
      chk("reset in_ready", 32'(in_ready), 32'd1);

      for (int i = 0; i < NV; i++) begin
         do_op(vecs[i], $sformatf("vec%0d", i));
      end

      // backpressure: result held, no new accept while out_ready is low
      start_op(4'h0, 32'd3, 32'd4);
      chk("bp out_valid", 32'(out_valid), 32'd1);
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("bp hold%0d result", i), result, 32'd7);
         chk($sformatf("bp hold%0d in_ready", i), 32'(in_ready), 32'd0);
         chk($sformatf("bp hold%0d out_valid", i), 32'(out_valid), 32'd1);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("bp release out_valid", 32'(out_valid), 32'd0);
      chk("bp release in_ready", 32'(in_ready), 32'd1);
      v = '{4'h4, 32'h0000_00FF, 32'h0000_000F, 32'h0000_00F0, 1'b0, 1'b0, 0};
      do_op(v, "bp next");

      // flush ten cycles into a 20-bit shift
      start_op(4'h1, 32'h0000_0001, 32'd20);
      repeat (9) step();
      chk("flush pre out_valid", 32'(out_valid), 32'd0);
      chk("flush pre in_ready", 32'(in_ready), 32'd0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush in_ready", 32'(in_ready), 32'd1);
      chk("flush out_valid", 32'(out_valid), 32'd0);
      chk("flush result held", result, 32'h0000_00F0);
      seen = 1'b0;
      for (int i = 0; i < 25; i++) begin
         step();
         seen = seen | out_valid;
      end
      chk("flush no late valid", 32'(seen), 32'd0);

      // flush on the same edge as a request suppresses the accept
      alu_op = 4'h0; op_a = 32'd1; op_b = 32'd1;
      in_valid = 1'b1;
      flush = 1'b1;
      step();
      in_valid = 1'b0;
      flush = 1'b0;
      chk("flush idle in_ready", 32'(in_ready), 32'd1);
      step();
      step();
      chk("flush idle out_valid", 32'(out_valid), 32'd0);
      chk("flush idle result", result, 32'h0000_00F0);

      // async reset in the middle of a shift
      start_op(4'h1, 32'h0000_0001, 32'd20);
      repeat (5) step();
      rst_n = 1'b0;
      #1;
      chk("rst mid out_valid", 32'(out_valid), 32'd0);
      chk("rst mid result", result, 32'd0);
      chk("rst mid in_ready", 32'(in_ready), 32'd1);
      step();
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 25; i++) begin
         step();
         seen = seen | out_valid;
      end
      chk("rst mid no valid", 32'(seen), 32'd0);
      v = '{4'h8, 32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, 1'b0, 0};
      do_op(v, "rst recover");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
